// File: rtl/cp0_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_unit_pkg
//  Description : Shared CPU definitions for the coprocessor-0 slice:
//                register numbers, SR/Cause field positions, the PRId
//                constant and small helpers used by cp0_unit and cp0_timer.
//  Revision    : 1.0  initial release
// ============================================================================
package cp0_unit_pkg;

    // CP0 register numbers as seen on the mfc0/mtc0 addr field
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_SR      = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;

    localparam logic [31:0] PRID_VALUE = 32'h4D43_5055;

    // Status register fields
    localparam int SR_IE_BIT  = 0;
    localparam int SR_EXL_BIT = 1;
    localparam int SR_IM_LO   = 10;
    localparam int SR_IM_HI   = 15;

    // Only IM, EXL and IE are implemented; everything else is read-as-zero
    localparam logic [31:0] SR_WRITE_MASK = 32'h0000_FC03;

    // Cause register fields: IP[14:10] are hardware lines, IP[15] is timer
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_HW_HI  = 14;
    localparam int CAUSE_TI_BIT = 15;

    // Controller strobes, packed as {exl_set, exl_clr}
    typedef struct packed {
        logic exl_set;
        logic exl_clr;
    } cp0_ctrl_t;

    // Return address is always word aligned
    function automatic logic [31:0] epc_align(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_unit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_timer
//  Description : Count/Compare timer. Count free-runs (wrapping) unless an
//                mtc0 loads it. TI latches one edge after Count==Compare
//                (Compare non-zero) and is cleared only by an mtc0 to Compare.
//  Ports       : clk, reset           - clock, sync active-high reset
//                we_count_i           - mtc0 to Count this cycle
//                we_compare_i         - mtc0 to Compare this cycle
//                wdata_i              - mtc0 data
//                count_o, compare_o   - current register values
//                ti_o                 - timer interrupt pending
//  Revision    : 1.0  initial release
// ============================================================================
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_count_i,
    input  logic        we_compare_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    logic [31:0] count_q,   count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q,      ti_d;

    always_comb begin
        count_d   = we_count_i   ? wdata_i : count_q + 32'd1;
        compare_d = we_compare_i ? wdata_i : compare_q;

        ti_d = ti_q;
        if ((count_q == compare_q) && (compare_q != 32'd0))
            ti_d = 1'b1;
        // Acknowledge via Compare write beats a coincident match
        if (we_compare_i)
            ti_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule
`default_nettype wire

// File: rtl/cp0_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_unit
//  Description : Coprocessor-0 for a small MIPS-like core. Holds SR, Cause,
//                EPC, PRId and the Count/Compare timer, generates the
//                interrupt request from registered state only.
//  Ports       : clk, reset           - clock, sync active-high reset
//                cp0_ctrl[1:0]        - {exl_set, exl_clr} from controller
//                victim_pc[31:0]      - resume PC saved into EPC on exl_set
//                we, addr, wdata      - mtc0 write port / mfc0 read address
//                hw_int[4:0]          - level-sensitive external interrupts
//                rdata[31:0]          - mfc0 data, combinational from addr
//                epc[31:0]            - EPC register, for eret
//                int_req              - interrupt request to controller
//  Revision    : 1.0  initial release
// ============================================================================
module cp0_unit
    import cp0_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  cp0_ctrl,
    input  logic [31:0] victim_pc,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  hw_int,
    output logic [31:0] rdata,
    output logic [31:0] epc,
    output logic        int_req
);

    cp0_ctrl_t   ctrl;
    logic [31:0] sr_q,  sr_d;
    logic [31:0] epc_q, epc_d;
    logic [4:0]  ip_q;
    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;
    logic [31:0] cause;
    logic [5:0]  pending;

    assign ctrl = cp0_ctrl;

    cp0_timer u_timer (
        .clk          (clk),
        .reset        (reset),
        .we_count_i   (we && (addr == CP0_COUNT)),
        .we_compare_i (we && (addr == CP0_COMPARE)),
        .wdata_i      (wdata),
        .count_o      (count),
        .compare_o    (compare),
        .ti_o         (ti)
    );

    // SR/EPC next state: exl_set has the final say over EXL and EPC even
    // when an mtc0 targets the same register in the same cycle.
    always_comb begin
        sr_d  = sr_q;
        epc_d = epc_q;

        if (we && (addr == CP0_SR))
            sr_d = wdata & SR_WRITE_MASK;
        if (we && (addr == CP0_EPC))
            epc_d = wdata;

        if (ctrl.exl_set) begin
            sr_d[SR_EXL_BIT] = 1'b1;
            epc_d            = epc_align(victim_pc);
        end else if (ctrl.exl_clr) begin
            sr_d[SR_EXL_BIT] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q  <= 32'd0;
            epc_q <= 32'd0;
            ip_q  <= 5'd0;
        end else begin
            sr_q  <= sr_d;
            epc_q <= epc_d;
            ip_q  <= hw_int;
        end
    end

    always_comb begin
        cause = 32'd0;
        cause[CAUSE_HW_HI:CAUSE_IP_LO] = ip_q;
        cause[CAUSE_TI_BIT]            = ti;
    end

    // Built only from flops so the controller sees no input-to-output path
    assign pending = cause[CAUSE_TI_BIT:CAUSE_IP_LO] & sr_q[SR_IM_HI:SR_IM_LO];
    assign int_req = sr_q[SR_IE_BIT] & ~sr_q[SR_EXL_BIT] & (|pending);

    always_comb begin
        rdata = 32'd0;
        case (addr)
            CP0_COUNT:   rdata = count;
            CP0_COMPARE: rdata = compare;
            CP0_SR:      rdata = sr_q;
            CP0_CAUSE:   rdata = cause;
            CP0_EPC:     rdata = epc_q;
            CP0_PRID:    rdata = PRID_VALUE;
            default:     rdata = 32'd0;
        endcase
    end

    assign epc = epc_q;

endmodule
`default_nettype wire

// File: tb/tb_cp0_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cp0_unit
//  Description : Directed bench for cp0_unit. Stimulus queues expectations
//                tagged with the cycle they apply to; a monitor on the
//                falling edge pops and compares them against the DUT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cp0_unit;

    localparam int K_INTREQ = 0;
    localparam int K_EPC    = 1;
    localparam int K_RDATA  = 2;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [1:0]  cp0_ctrl;
    logic [31:0] victim_pc;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [4:0]  hw_int;
    logic [31:0] rdata;
    logic [31:0] epc;
    logic        int_req;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    cp0_unit dut (
        .clk       (clk),
        .reset     (reset),
        .cp0_ctrl  (cp0_ctrl),
        .victim_pc (victim_pc),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .hw_int    (hw_int),
        .rdata     (rdata),
        .epc       (epc),
        .int_req   (int_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.kind)
                K_INTREQ: act = {31'd0, int_req};
                K_EPC:    act = epc;
                default:  act = rdata;
            endcase
            checks++;
            if (e.cyc != cyc || act !== e.exp) begin
                errors++;
                $display("FAIL %s: cycle %0d actual=%h expected=%h (due cycle %0d)",
                         e.name, cyc, act, e.exp, e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input int kind, input logic [31:0] v, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.exp  = v;
        e.name = name;
        q.push_back(e);
    endtask

    // Read a register: addr applied this cycle, rdata checked this cycle
    task automatic expect_reg(input logic [4:0] a, input logic [31:0] v, input string name);
        addr = a;
        expect_now(K_RDATA, v, name);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        step();
        we    = 1'b0;
        addr  = 5'd0;
    endtask

    initial begin
        reset     = 1'b1;
        cp0_ctrl  = 2'b00;
        victim_pc = 32'd0;
        we        = 1'b0;
        addr      = 5'd0;
        wdata     = 32'd0;
        hw_int    = 5'd0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        expect_now(K_INTREQ, 32'd0, "reset_intreq");
        expect_now(K_EPC, 32'd0, "reset_epc");
        expect_reg(5'd15, 32'h4D43_5055, "reset_prid");
        step();
        expect_reg(5'd12, 32'd0, "reset_sr");
        step();

        // Interrupt: IM[10]+IE, then hw_int[0]
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 5'b00001;
        expect_now(K_INTREQ, 32'd0, "int_before_sample");
        step();
        expect_now(K_INTREQ, 32'd1, "int_after_sample");
        expect_reg(5'd13, 32'h0000_0400, "cause_ip0");
        step();
        expect_now(K_INTREQ, 32'd1, "int_held");
        cp0_ctrl  = 2'b10;
        victim_pc = 32'h0000_3007;
        step();
        cp0_ctrl  = 2'b00;
        expect_now(K_EPC, 32'h0000_3004, "exl_set_epc");
        expect_now(K_INTREQ, 32'd0, "exl_set_masks");
        expect_reg(5'd12, 32'h0000_0403, "exl_set_sr");
        step();
        expect_reg(5'd14, 32'h0000_3004, "read_epc");
        step();

        // eret with the line still asserted
        cp0_ctrl = 2'b01;
        step();
        cp0_ctrl = 2'b00;
        expect_reg(5'd12, 32'h0000_0401, "eret_sr");
        expect_now(K_EPC, 32'h0000_3004, "eret_epc_kept");
        expect_now(K_INTREQ, 32'd1, "eret_intreq");
        hw_int = 5'd0;
        step();
        expect_now(K_INTREQ, 32'd0, "line_dropped");

        // Cause is read-only; undefined address reads zero
        mtc0(5'd13, 32'hFFFF_FFFF);
        expect_reg(5'd13, 32'd0, "cause_write_ignored");
        step();
        expect_reg(5'd3, 32'd0, "undef_addr");
        step();

        // Timer: IM[15]+IE, Count=0x10, Compare=0x14
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd9, 32'h0000_0010);
        mtc0(5'd11, 32'h0000_0014);
        // Count is 0x11 here and reaches 0x14 three cycles later; TI
        // lands on the following edge.
        expect_reg(5'd9, 32'h0000_0011, "count_after_load");
        step();
        step();
        step();
        expect_reg(5'd9, 32'h0000_0014, "count_match");
        expect_now(K_INTREQ, 32'd0, "timer_not_yet");
        step();
        expect_now(K_INTREQ, 32'd1, "timer_fired");
        expect_reg(5'd13, 32'h0000_8000, "cause_ti");
        step();
        mtc0(5'd11, 32'h0000_0100);
        expect_now(K_INTREQ, 32'd0, "timer_ack");
        expect_reg(5'd13, 32'd0, "cause_ti_clear");
        step();

        // Count wrap
        mtc0(5'd9, 32'hFFFF_FFFF);
        expect_reg(5'd9, 32'hFFFF_FFFF, "count_max");
        step();
        expect_reg(5'd9, 32'd0, "count_wrap");
        step();

        // exl_set and exl_clr together
        cp0_ctrl  = 2'b11;
        victim_pc = 32'h5555_5557;
        step();
        cp0_ctrl  = 2'b00;
        expect_reg(5'd12, 32'h0000_8003, "set_clr_exl");
        expect_now(K_EPC, 32'h5555_5554, "set_clr_epc");
        step();

        // exl_set with mtc0 EPC
        cp0_ctrl  = 2'b10;
        victim_pc = 32'h0000_ABCD;
        mtc0(5'd14, 32'h0000_1234);
        cp0_ctrl  = 2'b00;
        expect_now(K_EPC, 32'h0000_ABCC, "set_vs_mtc0_epc");
        step();

        // exl_set with mtc0 SR: other fields from wdata, EXL forced
        cp0_ctrl = 2'b10;
        mtc0(5'd12, 32'hFFFF_FC00);
        cp0_ctrl = 2'b00;
        expect_reg(5'd12, 32'h0000_FC02, "set_vs_mtc0_sr");
        step();

        // Reset mid-interrupt, against exl_set and we in the same cycle
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 5'b00001;
        step();
        expect_now(K_INTREQ, 32'd1, "pre_reset_int");
        reset     = 1'b1;
        cp0_ctrl  = 2'b10;
        victim_pc = 32'h0000_7777;
        mtc0(5'd12, 32'h0000_0401);
        reset    = 1'b0;
        cp0_ctrl = 2'b00;
        expect_now(K_INTREQ, 32'd0, "reset_mid_int");
        expect_now(K_EPC, 32'd0, "reset_mid_epc");
        expect_reg(5'd12, 32'd0, "reset_mid_sr");
        step();
        expect_reg(5'd15, 32'h4D43_5055, "prid_after_reset");
        step();
        hw_int = 5'd0;
        step();
        step();

        if (q.size() != 0) begin
            errors += q.size();
            $display("FAIL scoreboard: %0d expectations never checked", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
